// File: rtl/drc_route_engine.sv
// Device route controller: buffers dispatched packets, resolves each destination
// through one DAMC lookup with timeout, and emits it on the routed or unreachable channel.
module drc_route_engine #(
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 16,
    parameter int PORT_W         = 5,
    parameter int TYPE_W         = 6,
    parameter int DEPTH          = 4,
    parameter int LOOKUP_TIMEOUT = 15
) (
    input  logic              iClk,
    input  logic              iResetN,
    input  logic              DRC_PEC_pktDisValid,
    output logic              DRC_PEC_pktDisReady,
    input  logic [TYPE_W-1:0] DRC_PEC_pktDisType,
    input  logic [DATA_W-1:0] DRC_PEC_pktDisData,
    input  logic [ADDR_W-1:0] DRC_PEC_pktDisAddr,
    input  logic [PORT_W-1:0] DRC_PEC_pktDisPort,
    output logic              DRC_DAMC_lookupValid,
    output logic [ADDR_W-1:0] DRC_DAMC_lookupDeviceAddr,
    input  logic              DRC_DAMC_lookupRspValid,
    input  logic [PORT_W-1:0] DRC_DAMC_lookupRspPort,
    output logic              DRC_routeValid,
    input  logic              DRC_routeReady,
    output logic [TYPE_W-1:0] DRC_routeType,
    output logic [DATA_W-1:0] DRC_routeData,
    output logic [ADDR_W-1:0] DRC_routeSrcAddr,
    output logic [PORT_W-1:0] DRC_routeDestPort,
    output logic              DRC_unreachValid,
    input  logic              DRC_unreachReady,
    output logic [PORT_W-1:0] DRC_unreachPort,
    output logic [ADDR_W-1:0] DRC_unreachAddr,
    output logic [7:0]        DRC_dropCnt,
    output logic [7:0]        DRC_timeoutCnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(LOOKUP_TIMEOUT + 1);

    localparam logic [TYPE_W-1:0] UPREQ = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] DNREQ = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] UPRSP = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] DNRSP = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] UPDAT = TYPE_W'(5);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [PORT_W-1:0] port;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [1:0]        state;
    logic [TW-1:0]     timer;
    logic              mode_route;
    logic [PORT_W-1:0] dest_port;
    logic [7:0]        drop_cnt;
    logic [7:0]        tmo_cnt;

    logic type_ok, accept, push, pop, out_valid;

    assign head    = mem[rd_ptr];
    assign type_ok = (DRC_PEC_pktDisType == UPREQ) || (DRC_PEC_pktDisType == DNREQ) ||
                     (DRC_PEC_pktDisType == UPRSP) || (DRC_PEC_pktDisType == DNRSP) ||
                     (DRC_PEC_pktDisType == UPDAT);

    // Ready comes only from the registered count; a same-cycle pop does not help.
    assign DRC_PEC_pktDisReady = iResetN & (count != CW'(DEPTH));
    assign accept = DRC_PEC_pktDisValid & DRC_PEC_pktDisReady;
    assign push   = accept & type_ok;

    assign out_valid        = iResetN && (state == ST_OUT);
    assign DRC_routeValid   = out_valid & mode_route;
    assign DRC_unreachValid = out_valid & ~mode_route;
    assign pop = (DRC_routeValid & DRC_routeReady) | (DRC_unreachValid & DRC_unreachReady);

    assign DRC_DAMC_lookupValid      = iResetN && (state == ST_REQ);
    assign DRC_DAMC_lookupDeviceAddr = DRC_DAMC_lookupValid ? head.addr : '0;

    // Fields are zero whenever their channel is idle, so reset forces every output low.
    assign DRC_routeType     = DRC_routeValid ? head.typ  : '0;
    assign DRC_routeData     = DRC_routeValid ? head.data : '0;
    assign DRC_routeSrcAddr  = DRC_routeValid ? head.addr : '0;
    assign DRC_routeDestPort = DRC_routeValid ? dest_port : '0;
    assign DRC_unreachPort   = DRC_unreachValid ? head.port : '0;
    assign DRC_unreachAddr   = DRC_unreachValid ? head.addr : '0;
    assign DRC_dropCnt       = drop_cnt;
    assign DRC_timeoutCnt    = tmo_cnt;

    always_ff @(posedge iClk) begin
        if (push) mem[wr_ptr] <= '{typ: DRC_PEC_pktDisType, data: DRC_PEC_pktDisData,
                                   addr: DRC_PEC_pktDisAddr, port: DRC_PEC_pktDisPort};
    end

    always_ff @(posedge iClk) begin
        if (!iResetN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && !type_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iResetN) begin
            state      <= ST_IDLE;
            timer      <= '0;
            mode_route <= 1'b0;
            dest_port  <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (count != '0) state <= ST_REQ;
                ST_REQ: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    // A response in the final cycle beats the timeout.
                    if (DRC_DAMC_lookupRspValid) begin
                        mode_route <= (DRC_DAMC_lookupRspPort != '0);
                        dest_port  <= DRC_DAMC_lookupRspPort;
                        state      <= ST_OUT;
                    end else if (timer == TW'(LOOKUP_TIMEOUT - 1)) begin
                        mode_route <= 1'b0;
                        if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 1'b1;
                        state      <= ST_OUT;
                    end
                end
                ST_OUT:  if (pop) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
